// File: rtl/lsu_pkg.sv
// Shared types for the data-memory load/store unit: FSM states, RV32I width codes, request legality.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // A request is refused (error response, no bus traffic) when its width
  // code is unknown for its direction or its address is not naturally aligned.
  function automatic logic req_bad(input logic we, input logic [2:0] funct3,
                                   input logic [1:0] off);
    logic illegal;
    logic misaligned;
    illegal    = we ? (funct3 >= 3'd3)
                    : (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
    misaligned = 1'b0;
    case (funct3)
      F3_H, F3_HU: misaligned = off[0];
      F3_W:        misaligned = (off != 2'b00);
      default:     misaligned = 1'b0;
    endcase
    // Width code 5 is a store-illegal code, caught above before alignment matters.
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Core-side request bundle and Dmem-port bundle for the load/store unit.
// Latency: n/a (wiring only).
// Backpressure: core stalls on lsu_busy; the memory stretches accesses with mem_wait.
interface lsu_core_if;
  logic        lsu_req;
  logic        lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_busy;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic        lsu_err;

  modport master (
    output lsu_req, lsu_we, lsu_funct3, lsu_addr, lsu_wdata,
    input  lsu_busy, lsu_done, lsu_rdata, lsu_err
  );

  modport slave (
    input  lsu_req, lsu_we, lsu_funct3, lsu_addr, lsu_wdata,
    output lsu_busy, lsu_done, lsu_rdata, lsu_err
  );
endinterface

interface dmem_bus_if;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_access;
  logic [31:0] mem_rdata;
  logic        mem_wait;

  modport master (
    output mem_addr, mem_we, mem_wdata, mem_access,
    input  mem_rdata, mem_wait
  );

  modport slave (
    input  mem_addr, mem_we, mem_wdata, mem_access,
    output mem_rdata, mem_wait
  );
endinterface

// File: rtl/lsu_align.sv
// Byte/half extraction with sign/zero extension for loads, and read-modify-write merge for SB/SH.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [31:0] shifted;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  logic [31:0] mask;
  logic [31:0] ins;

  // Extract the addressed lane and extend it according to the width code.
  always_comb begin
    shifted = rword >> {byte_off, 3'b000};
    sel_b   = shifted[7:0];
    sel_h   = shifted[15:0];
    case (funct3)
      F3_B:    load_data = {{24{sel_b[7]}}, sel_b};
      F3_H:    load_data = {{16{sel_h[15]}}, sel_h};
      F3_W:    load_data = rword;
      F3_BU:   load_data = {24'd0, sel_b};
      F3_HU:   load_data = {16'd0, sel_h};
      default: load_data = 32'd0;
    endcase
  end

  // Overlay the store lane onto the word just read; untouched bytes keep memory contents.
  always_comb begin
    mask = 32'd0;
    ins  = 32'd0;
    case (funct3)
      F3_B: begin
        mask = 32'h0000_00FF << {byte_off, 3'b000};
        ins  = {24'd0, wdata[7:0]} << {byte_off, 3'b000};
      end
      F3_H: begin
        mask = 32'h0000_FFFF << {byte_off[1], 4'b0000};
        ins  = {16'd0, wdata[15:0]} << {byte_off[1], 4'b0000};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        ins  = wdata;
      end
    endcase
    merge_data = (rword & ~mask) | (ins & mask);
  end

endmodule

// File: rtl/dmem_lsu.sv
// RV32I load/store unit driving a single-port Dmem bus; sub-word stores done as read-modify-write.
// Latency: done 2 cycles after accept (loads/SW), 3 (SB/SH), 1 (errors), +1 per mem_wait cycle.
// Backpressure: requests only taken in IDLE (lsu_busy low); mem_wait stretches, bounded by TIMEOUT_CYCLES.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  lsu_core_if.slave    core,
  dmem_bus_if.master   mem
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        we_r;
  logic [2:0]  f3_r;
  logic [1:0]  off_r;
  logic [31:0] wdata_r;
  logic [7:0]  wait_cnt;

  logic        acc_q;
  logic        mwe_q;
  logic [31:0] maddr_q;
  logic [31:0] mwdata_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [31:0] load_data;
  logic [31:0] merge_data;
  logic        wait_expired;

  lsu_align u_align (
    .funct3     (f3_r),
    .byte_off   (off_r),
    .rword      (mem.mem_rdata),
    .wdata      (wdata_r),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  assign wait_expired = mem.mem_wait && (wait_cnt == WAIT_LAST);

  // Request FSM; every bus and response output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      we_r     <= 1'b0;
      f3_r     <= 3'd0;
      off_r    <= 2'd0;
      wdata_r  <= 32'd0;
      wait_cnt <= 8'd0;
      acc_q    <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= 32'd0;
      mwdata_q <= 32'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= 32'd0;
          if (core.lsu_req) begin
            we_r     <= core.lsu_we;
            f3_r     <= core.lsu_funct3;
            off_r    <= core.lsu_addr[1:0];
            wdata_r  <= core.lsu_wdata;
            wait_cnt <= 8'd0;
            if (req_bad(core.lsu_we, core.lsu_funct3, core.lsu_addr[1:0])) begin
              state  <= ST_RESP;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else if (core.lsu_we && core.lsu_funct3 == F3_W) begin
              state    <= ST_WRITE;
              acc_q    <= 1'b1;
              mwe_q    <= 1'b1;
              maddr_q  <= {core.lsu_addr[31:2], 2'b00};
              mwdata_q <= core.lsu_wdata;
            end else begin
              // Loads and sub-word stores both start by reading the word.
              state    <= ST_READ;
              acc_q    <= 1'b1;
              mwe_q    <= 1'b0;
              maddr_q  <= {core.lsu_addr[31:2], 2'b00};
              mwdata_q <= 32'd0;
            end
          end
        end

        ST_READ: begin
          if (!mem.mem_wait) begin
            if (we_r) begin
              state    <= ST_WRITE;
              mwe_q    <= 1'b1;
              mwdata_q <= merge_data;
              wait_cnt <= 8'd0;
            end else begin
              state   <= ST_RESP;
              acc_q   <= 1'b0;
              maddr_q <= 32'd0;
              rdata_q <= load_data;
              done_q  <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_expired) begin
              state    <= ST_RESP;
              acc_q    <= 1'b0;
              mwe_q    <= 1'b0;
              maddr_q  <= 32'd0;
              mwdata_q <= 32'd0;
              done_q   <= 1'b1;
              err_q    <= 1'b1;
            end
          end
        end

        ST_WRITE: begin
          if (mem.mem_wait) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
          if (!mem.mem_wait || wait_expired) begin
            // Either the write landed or we give up; the bus is released either way.
            state    <= ST_RESP;
            acc_q    <= 1'b0;
            mwe_q    <= 1'b0;
            maddr_q  <= 32'd0;
            mwdata_q <= 32'd0;
            done_q   <= 1'b1;
            err_q    <= mem.mem_wait;
          end
        end

        ST_RESP: begin
          state   <= ST_IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= 32'd0;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are forced low for as long as reset is held, not just after the first edge.
  assign core.lsu_busy  = rst_n && (state != ST_IDLE);
  assign core.lsu_done  = rst_n && done_q;
  assign core.lsu_err   = rst_n && err_q;
  assign core.lsu_rdata = rst_n ? rdata_q : 32'd0;

  assign mem.mem_access = rst_n && acc_q;
  assign mem.mem_we     = rst_n && mwe_q;
  assign mem.mem_addr   = rst_n ? maddr_q : 32'd0;
  assign mem.mem_wdata  = rst_n ? mwdata_q : 32'd0;

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;

  logic clk;
  logic rst_n;
  logic mem_load;
  logic stall_all;

  int checks;
  int errors;

  lsu_core_if core ();
  dmem_bus_if bus ();

  dmem_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .core  (core),
    .mem   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 16 words, addresses with addr[3:2]=11 wait 2 cycles per access.
  logic [31:0] mem [16];
  int          wctr;
  int          nrd;
  int          nwr;
  int          nacc;

  assign bus.mem_rdata = mem[bus.mem_addr[5:2]];
  assign bus.mem_wait  = bus.mem_access &&
                         (stall_all || (bus.mem_addr[3:2] == 2'b11 && wctr < 2));

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
      mem[0] <= 32'h8081_7F01;
      mem[1] <= 32'h1122_3344;
      mem[3] <= 32'hCAFE_BABE;
      wctr <= 0;
      nrd  <= 0;
      nwr  <= 0;
      nacc <= 0;
    end else begin
      if (bus.mem_access) nacc <= nacc + 1;
      if (bus.mem_access && bus.mem_wait) wctr <= wctr + 1;
      else wctr <= 0;
      if (bus.mem_access && !bus.mem_wait) begin
        if (bus.mem_we) begin
          mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
          nwr <= nwr + 1;
        end else begin
          nrd <= nrd + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request in an IDLE cycle and wait (bounded) for lsu_done.
  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, output int lat,
                     output logic [31:0] rd, output logic er);
    lat = -1;
    rd  = 32'hxxxx_xxxx;
    er  = 1'bx;
    @(negedge clk);
    core.lsu_req    = 1'b1;
    core.lsu_we     = we;
    core.lsu_funct3 = f3;
    core.lsu_addr   = addr;
    core.lsu_wdata  = wdata;
    @(posedge clk);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) core.lsu_req = 1'b0;
      if (core.lsu_done) begin
        lat = i;
        rd  = core.lsu_rdata;
        er  = core.lsu_err;
        break;
      end
    end
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          rd0, wr0, acc0;

    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    mem_load = 1'b1;
    stall_all = 1'b0;
    core.lsu_req = 1'b0;
    core.lsu_we = 1'b0;
    core.lsu_funct3 = 3'd0;
    core.lsu_addr = 32'd0;
    core.lsu_wdata = 32'd0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(core.lsu_busy), 32'd0);
    chk("rst_done", 32'(core.lsu_done), 32'd0);
    chk("rst_rdata", core.lsu_rdata, 32'd0);
    chk("rst_outs", {28'd0, core.lsu_err, bus.mem_access, bus.mem_we, |bus.mem_addr}, 32'd0);
    mem_load = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Loads from word 0 = 80817F01
    run(1'b0, 3'd0, 32'h001, 32'd0, lat, rd, er);
    chk("lb1_data", rd, 32'h0000_007F);
    chk("lb1_lat", 32'(lat), 32'd2);
    chk("lb1_err", 32'(er), 32'd0);
    @(negedge clk);
    chk("lb1_done_pulse", 32'(core.lsu_done), 32'd0);
    run(1'b0, 3'd0, 32'h003, 32'd0, lat, rd, er);
    chk("lb3_data", rd, 32'hFFFF_FF80);
    chk("lb3_lat", 32'(lat), 32'd2);
    run(1'b0, 3'd5, 32'h002, 32'd0, lat, rd, er);
    chk("lhu2_data", rd, 32'h0000_8081);
    chk("lhu2_lat", 32'(lat), 32'd2);
    run(1'b0, 3'd1, 32'h002, 32'd0, lat, rd, er);
    chk("lh2_data", rd, 32'hFFFF_8081);

    // SB read-modify-write into word 1
    rd0 = nrd; wr0 = nwr;
    run(1'b1, 3'd0, 32'h005, 32'h0000_00AB, lat, rd, er);
    chk("sb_lat", 32'(lat), 32'd3);
    chk("sb_rdata", rd, 32'd0);
    chk("sb_err", 32'(er), 32'd0);
    chk("sb_word", mem[1], 32'h1122_AB44);
    chk("sb_reads", 32'(nrd - rd0), 32'd1);
    chk("sb_writes", 32'(nwr - wr0), 32'd1);

    // Slow address: two wait cycles
    run(1'b0, 3'd2, 32'h00C, 32'd0, lat, rd, er);
    chk("lw_slow_data", rd, 32'hCAFE_BABE);
    chk("lw_slow_lat", 32'(lat), 32'd4);
    run(1'b1, 3'd2, 32'h00C, 32'h1234_5678, lat, rd, er);
    chk("sw_slow_lat", 32'(lat), 32'd4);
    chk("sw_slow_word", mem[3], 32'h1234_5678);

    // Refused requests never touch the bus
    acc0 = nacc;
    run(1'b1, 3'd1, 32'h001, 32'h0000_BEEF, lat, rd, er);
    chk("sh_mis_err", 32'(er), 32'd1);
    chk("sh_mis_lat", 32'(lat), 32'd1);
    chk("sh_mis_rdata", rd, 32'd0);
    run(1'b0, 3'd3, 32'h000, 32'd0, lat, rd, er);
    chk("lw_ill_err", 32'(er), 32'd1);
    chk("lw_ill_lat", 32'(lat), 32'd1);
    chk("err_no_access", 32'(nacc - acc0), 32'd0);

    // Timeout after 4 wait cycles, then recovery
    stall_all = 1'b1;
    run(1'b0, 3'd2, 32'h000, 32'd0, lat, rd, er);
    chk("tmo_err", 32'(er), 32'd1);
    chk("tmo_rdata", rd, 32'd0);
    chk("tmo_lat", 32'(lat), 32'd5);
    chk("tmo_access_off", 32'(bus.mem_access), 32'd0);
    stall_all = 1'b0;
    run(1'b0, 3'd2, 32'h000, 32'd0, lat, rd, er);
    chk("post_tmo_data", rd, 32'h8081_7F01);
    chk("post_tmo_err", 32'(er), 32'd0);
    chk("post_tmo_lat", 32'(lat), 32'd2);

    // Request held through RESP is only taken in the following IDLE cycle
    run(1'b0, 3'd2, 32'h004, 32'd0, lat, rd, er);
    core.lsu_req = 1'b1;
    core.lsu_we = 1'b1;
    core.lsu_funct3 = 3'd2;
    core.lsu_addr = 32'h008;
    core.lsu_wdata = 32'h5A5A_5A5A;
    @(negedge clk);
    chk("b2b_not_in_resp", 32'(core.lsu_busy), 32'd0);
    @(negedge clk);
    chk("b2b_accepted", 32'(core.lsu_busy), 32'd1);
    core.lsu_req = 1'b0;
    lat = -1;
    for (int i = 2; i <= 30; i++) begin
      @(negedge clk);
      if (core.lsu_done) begin
        lat = i;
        break;
      end
    end
    chk("b2b_lat", 32'(lat), 32'd2);
    chk("b2b_word", mem[2], 32'h5A5A_5A5A);

    // Reset during the write phase of an SB to the slow word
    @(negedge clk);
    core.lsu_req = 1'b1;
    core.lsu_we = 1'b1;
    core.lsu_funct3 = 3'd0;
    core.lsu_addr = 32'h00D;
    core.lsu_wdata = 32'h0000_00EE;
    @(posedge clk);
    @(negedge clk);
    core.lsu_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstw_in_write", 32'(bus.mem_we), 32'd1);
    chk("rstw_merged", bus.mem_wdata, 32'h1234_EE78);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstw_busy", 32'(core.lsu_busy), 32'd0);
    chk("rstw_done", 32'(core.lsu_done), 32'd0);
    chk("rstw_bus", {30'd0, bus.mem_access, bus.mem_we}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstw_idle_after", 32'(core.lsu_busy), 32'd0);
    chk("rstw_no_write", mem[3], 32'h1234_5678);
    run(1'b0, 3'd4, 32'h00D, 32'd0, lat, rd, er);
    chk("rstw_lbu_data", rd, 32'h0000_0056);
    chk("rstw_lbu_lat", 32'(lat), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, maximum consecutive mem_wait cycles tolerated per bus access (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 lsu_req  input  1  core request strobe; sampled only in IDLE.
REQ-005 lsu_we  input  1  1 = store, 0 = load.
REQ-006 lsu_funct3  input  3  RV32I width code: LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2.
REQ-007 lsu_addr  input  32  byte address.
REQ-008 lsu_wdata  input  32  store data, right-aligned.
REQ-009 lsu_busy  output  1  high whenever state != IDLE; the core stalls on it.
REQ-010 lsu_done  output  1  one-cycle completion pulse.
REQ-011 lsu_rdata  output  32  extended load result, valid while lsu_done=1.
REQ-012 lsu_err  output  1  misaligned, illegal funct3 or timeout; valid while lsu_done=1.
REQ-013 mem_addr  output  32  word address to the mem_bus Dmem port, {addr[31:2],2'b00}.
REQ-014 mem_we  output  1  drives Dwe.
REQ-015 mem_wdata  output  32  drives Dwritedata.
REQ-016 mem_access  output  1  drives Dmemaccess.
REQ-017 mem_rdata  input  32  Dreaddata; combinational, valid when mem_access=1 and mem_wait=0.
REQ-018 mem_wait  input  1  Dwait; the access completes on the first edge with mem_wait=0.

Function
REQ-019 FSM states: IDLE, READ, WRITE, RESP; each request is captured into internal registers on acceptance in IDLE.
REQ-020 IDLE with lsu_req=1: a load, SB or SH goes to READ; SW goes to WRITE; a misaligned or illegal request goes to RESP with the error flag set and performs no bus activity.
REQ-021 Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0; illegal: load funct3 in {3,6,7}, store funct3 >= 3.
REQ-022 READ: mem_access=1, mem_we=0; on an edge with mem_wait=0, a load registers the extracted result and goes to RESP, while SB/SH registers the merged word and goes to WRITE.
REQ-023 Extract: the byte/half is selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend; LW passes the word through.
REQ-024 Merge: SB replaces byte addr[1:0] with wdata[7:0]; SH replaces half addr[1] with wdata[15:0]; all other bytes come from mem_rdata.
REQ-025 WRITE: mem_access=1, mem_we=1, mem_wdata = merged word or SW data, held constant; on an edge with mem_wait=0, go to RESP.
REQ-026 RESP: lsu_done=1 for exactly one cycle, then IDLE; lsu_rdata=0 for stores and error responses.
REQ-027 Latency with no wait: lsu_done is asserted 2 cycles after acceptance for loads and SW, 3 cycles for SB/SH, and 1 cycle for errors; each mem_wait cycle adds one cycle.
REQ-028 Wait counter: it clears on entering READ or WRITE and increments on each cycle with mem_wait=1.
REQ-029 Timeout: reaching TIMEOUT_CYCLES forces RESP with lsu_err=1, deasserts mem_we and mem_access, and issues no further write for that request.
REQ-030 Back-to-back requests: lsu_req is ignored outside IDLE, so a request in the RESP cycle is not accepted; the earliest next acceptance is the following IDLE cycle.
REQ-031 mem_addr, mem_wdata and mem_we are 0 whenever mem_access=0.

Reset
REQ-032 rst_n=0 at any edge forces IDLE and clears the counter and captured registers.
REQ-033 While rst_n=0, all outputs are 0.
REQ-034 Reset mid-READ or mid-WRITE abandons the request with no lsu_done; mem_we is low from the next cycle.

Structure
REQ-035 Package lsu_pkg holds the state enum and the funct3 localparams.
REQ-036 The combinational extract/merge logic lives in one sub-module, lsu_align.
REQ-037 Implementation size is 120-400 RTL lines; the block connects to the mem_bus Dmem modport and needs no changes to the cache.

Verification
REQ-038 Loads: with word 0 = 0x80817F01: LB 0x001 -> 0x0000007F; LB 0x003 -> 0xFFFFFF80; LHU 0x002 -> 0x00008081; each lsu_done 2 cycles after lsu_req.
REQ-039 SB: addr 0x005, wdata 0x000000AB, word 1 = 0x11223344 -> word 1 = 0x1122AB44; one read, then one write; lsu_done at cycle 3.
REQ-040 Wait: LW 0x00C (addr[3:2]=11, 2-cycle Dwait model) -> lsu_done at cycle 4 with correct data; SW 0x00C -> write lands and lsu_done at cycle 4.
REQ-041 Error: SH 0x001 and LW funct3=3 -> lsu_err=1, lsu_done at cycle 1, mem_access never asserted.
REQ-042 Timeout: TIMEOUT_CYCLES=4 with mem_wait held 1 -> lsu_err=1, lsu_rdata=0, lsu_done after 4 wait cycles; then a normal LW succeeds.
REQ-043 Reset: rst_n=0 during a SB WRITE -> next cycle is IDLE with all outputs 0, no lsu_done; a subsequent request completes normally.
